// File: rtl/sleepwell_pkg.sv
//============================================================================
// Module   : sleepwell_pkg
// Purpose  : Shared phase encoding, brightness limit and 640x480@60 timing
//            defaults for the sleepwell VGA controller.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package sleepwell_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_DIM   = 2'd1,
    PH_SLEEP = 2'd2,
    PH_WAKE  = 2'd3
  } phase_e;

  localparam logic [5:0] LEVEL_MAX = 6'd63;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_SLEEP_FRAMES = 120;

  // Brightness never wraps past full scale on the way up.
  function automatic logic [5:0] level_inc(input logic [5:0] lvl);
    return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + 6'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sleepwell_vga_ctrl_if.sv
//============================================================================
// Module   : sleepwell_vga_ctrl_if
// Purpose  : Control inputs and video/brightness outputs of the controller.
//            SLEEPWELL_TEST_PATTERN_EN adds the bar output.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sleepwell_vga_ctrl_if;
  import sleepwell_pkg::*;

  logic       go;
  logic       abort;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  phase_e     phase;
  logic [5:0] level;
`ifdef SLEEPWELL_TEST_PATTERN_EN
  logic [2:0] bar;
`endif

  modport master (
    input  go,
    input  abort,
    output hsync,
    output vsync,
    output de,
    output x,
    output y,
    output frame_start,
    output phase,
    output level
`ifdef SLEEPWELL_TEST_PATTERN_EN
    ,
    output bar
`endif
  );

  modport slave (
    output go,
    output abort,
    input  hsync,
    input  vsync,
    input  de,
    input  x,
    input  y,
    input  frame_start,
    input  phase,
    input  level
`ifdef SLEEPWELL_TEST_PATTERN_EN
    ,
    input  bar
`endif
  );

endinterface

`default_nettype wire

// File: rtl/sleepwell_vga_timing.sv
//============================================================================
// Module   : sleepwell_vga_timing
// Purpose  : Pixel/line counters with sync, display-enable and frame-start
//            decode, all taken from the same counter registers.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module sleepwell_vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] C_HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] C_VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       w_x_last;
  logic       w_y_last;

  assign w_x_last = (r_x == C_H_LAST);
  assign w_y_last = (r_y == C_V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_x_last) begin
      r_x <= '0;
      r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
    end else begin
      r_x <= r_x + 10'd1;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = !((r_x >= C_HS_START) && (r_x < C_HS_END));
  assign vsync       = !((r_y >= C_VS_START) && (r_y < C_VS_END));
  assign de          = (r_x < C_H_ACT) && (r_y < C_V_ACT);
  assign frame_start = w_x_last && w_y_last;

endmodule

`default_nettype wire

// File: rtl/sleepwell_vga_ctrl.sv
//============================================================================
// Module   : sleepwell_vga_ctrl
// Purpose  : VGA timing plus a frame-paced dim/sleep/wake brightness FSM.
//            Optional macro SLEEPWELL_TEST_PATTERN_EN adds a colour-bar index.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module sleepwell_vga_ctrl
  import sleepwell_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int SLEEP_FRAMES = DEF_SLEEP_FRAMES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sleepwell_vga_ctrl_if.master bus
);

  localparam logic [7:0] C_SLEEP_LOAD = 8'(SLEEP_FRAMES);

  logic [9:0] w_x;
  logic [9:0] w_y;
  logic       w_de;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_fs;

  sleepwell_vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (w_x),
    .y           (w_y),
    .hsync       (w_hsync),
    .vsync       (w_vsync),
    .de          (w_de),
    .frame_start (w_fs)
  );

  phase_e     r_phase;
  phase_e     w_phase_nxt;
  logic [5:0] r_level;
  logic [5:0] w_level_nxt;
  logic [7:0] r_sleep_cnt;
  logic [7:0] w_sleep_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= PH_IDLE;
      r_level     <= LEVEL_MAX;
      r_sleep_cnt <= 8'd0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_level     <= w_level_nxt;
      r_sleep_cnt <= w_sleep_cnt_nxt;
    end
  end

  // State only advances on the last pixel of a frame, so every frame is uniform.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_level_nxt     = r_level;
    w_sleep_cnt_nxt = r_sleep_cnt;
    if (w_fs) begin
      unique case (r_phase)
        PH_IDLE: begin
          w_level_nxt = LEVEL_MAX;
          if (bus.go && !bus.abort) begin
            w_phase_nxt = PH_DIM;
            w_level_nxt = LEVEL_MAX - 6'd1;
          end
        end
        PH_DIM: begin
          if (bus.abort) begin
            w_phase_nxt = PH_WAKE;
            w_level_nxt = level_inc(r_level);
          end else if (r_level == 6'd0) begin
            w_phase_nxt     = PH_SLEEP;
            w_sleep_cnt_nxt = C_SLEEP_LOAD;
          end else begin
            w_level_nxt = r_level - 6'd1;
          end
        end
        PH_SLEEP: begin
          if (bus.abort || (r_sleep_cnt <= 8'd1)) begin
            w_phase_nxt     = PH_WAKE;
            w_level_nxt     = level_inc(r_level);
            w_sleep_cnt_nxt = 8'd0;
          end else begin
            w_sleep_cnt_nxt = r_sleep_cnt - 8'd1;
          end
        end
        PH_WAKE: begin
          if (r_level == LEVEL_MAX) begin
            w_phase_nxt = PH_IDLE;
          end else begin
            w_level_nxt = level_inc(r_level);
          end
        end
        default: begin
          w_phase_nxt = PH_IDLE;
          w_level_nxt = LEVEL_MAX;
        end
      endcase
    end
  end

  assign bus.x           = w_x;
  assign bus.y           = w_y;
  assign bus.hsync       = w_hsync;
  assign bus.vsync       = w_vsync;
  assign bus.de          = w_de;
  assign bus.frame_start = w_fs;
  assign bus.phase       = r_phase;

`ifdef SLEEPWELL_TEST_PATTERN_EN
  assign bus.level = ((r_phase == PH_IDLE) && !bus.go) ? LEVEL_MAX : r_level;
  assign bus.bar   = w_de ? w_x[9:7] : 3'd0;
`else
  assign bus.level = r_level;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sleepwell_vga_ctrl.sv
//============================================================================
// Module   : tb_sleepwell_vga_ctrl
// Purpose  : Directed self-checking bench for sleepwell_vga_ctrl using a
//            shrunken 20x10 raster so whole dim/sleep/wake cycles stay short.
// Revision : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sleepwell_vga_ctrl;
  import sleepwell_pkg::*;

  localparam int HA = 10, HFP = 2, HS = 3, HBP = 5;
  localparam int VA = 5,  VFP = 1, VS = 2, VBP = 2;
  localparam int SF = 4;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int LIMIT = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int h_low, v_low, de_cnt, fs_cnt, fs_x, fs_y, hs_first, vs_first, vs_last;
  int exp_phase, exp_level, lat;

  sleepwell_vga_ctrl_if vif ();

  sleepwell_vga_ctrl #(
    .H_ACTIVE     (HA),
    .H_FP         (HFP),
    .H_SYNC       (HS),
    .H_BP         (HBP),
    .V_ACTIVE     (VA),
    .V_FP         (VFP),
    .V_SYNC       (VS),
    .V_BP         (VBP),
    .SLEEP_FRAMES (SF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the falling edge just after the frame_start clock edge.
  task automatic wait_frame();
    int n = 0;
    while (!vif.frame_start && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_val("frame_timeout", 32'(vif.frame_start), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_xy(input int tx, input int ty);
    int n = 0;
    while (!(vif.x == 10'(tx) && vif.y == 10'(ty)) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check_val("xy_timeout", 32'(vif.x), 32'(tx));
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_x"},     32'(vif.x), 32'd0);
    check_val({pfx, "_y"},     32'(vif.y), 32'd0);
    check_val({pfx, "_phase"}, 32'(vif.phase), 32'd0);
    check_val({pfx, "_level"}, 32'(vif.level), 32'd63);
    check_val({pfx, "_fs"},    32'(vif.frame_start), 32'd0);
    check_val({pfx, "_hsync"}, 32'(vif.hsync), 32'd1);
    check_val({pfx, "_vsync"}, 32'(vif.vsync), 32'd1);
    check_val({pfx, "_de"},    32'(vif.de), 32'd1);
  endtask

  initial begin
    vif.go    = 1'b0;
    vif.abort = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // One full raster after release: sync widths/positions, de area, frame_start.
    rst_n = 1'b1;
    h_low = 0; v_low = 0; de_cnt = 0; fs_cnt = 0;
    fs_x = -1; fs_y = -1; hs_first = -1; vs_first = -1; vs_last = -1;
    for (int i = 0; i < HT * VT; i++) begin
      if (!vif.hsync) begin
        h_low++;
        if (hs_first < 0) hs_first = int'(vif.x);
      end
      if (!vif.vsync) begin
        v_low++;
        if (vs_first < 0) vs_first = int'(vif.y);
        vs_last = int'(vif.y);
      end
      if (vif.de) de_cnt++;
      if (vif.frame_start) begin
        fs_cnt++;
        fs_x = int'(vif.x);
        fs_y = int'(vif.y);
      end
      @(negedge clk);
    end
    check_val("hsync_low_clocks", 32'(h_low), 32'd30);
    check_val("hsync_first_x",    32'(hs_first), 32'd12);
    check_val("vsync_low_clocks", 32'(v_low), 32'd40);
    check_val("vsync_first_y",    32'(vs_first), 32'd6);
    check_val("vsync_last_y",     32'(vs_last), 32'd7);
    check_val("de_count",         32'(de_cnt), 32'd50);
    check_val("fs_count",         32'(fs_cnt), 32'd1);
    check_val("fs_x",             32'(fs_x), 32'd19);
    check_val("fs_y",             32'(fs_y), 32'd9);
    check_val("wrap_x",           32'(vif.x), 32'd0);
    check_val("wrap_y",           32'(vif.y), 32'd0);
    check_val("idle_no_go",       32'(vif.phase), 32'(PH_IDLE));

    // A one-clock go away from frame_start is lost.
    wait_xy(5, 0);
    vif.go = 1'b1;
    @(negedge clk);
    vif.go = 1'b0;
    wait_frame();
    check_val("go_pulse_phase", 32'(vif.phase), 32'(PH_IDLE));

    // go together with abort in IDLE: abort wins, nothing starts.
    vif.go    = 1'b1;
    vif.abort = 1'b1;
    wait_frame();
    check_val("go_abort_phase", 32'(vif.phase), 32'(PH_IDLE));
    check_val("go_abort_level", 32'(vif.level), 32'd63);
    vif.go    = 1'b0;
    vif.abort = 1'b0;

    // Full cycle with go held: DIM 62..0, SLEEP 4 frames, WAKE 1..63, then IDLE.
    vif.go = 1'b1;
    for (int k = 0; k <= 130; k++) begin
      wait_frame();
      if (k <= 62) begin
        exp_phase = 1; exp_level = 62 - k;
      end else if (k <= 66) begin
        exp_phase = 2; exp_level = 0;
      end else if (k <= 129) begin
        exp_phase = 3; exp_level = k - 66;
      end else begin
        exp_phase = 0; exp_level = 63;
      end
      check_val("cycle_phase", 32'(vif.phase), 32'(exp_phase));
      check_val("cycle_level", 32'(vif.level), 32'(exp_level));
    end
    vif.go = 1'b0;

    // Abort in DIM at level 40 wakes from 41; abort is ignored once in WAKE.
    vif.go = 1'b1;
    wait_frame();
    vif.go = 1'b0;
    check_val("abort_dim_start", 32'(vif.level), 32'd62);
    repeat (22) wait_frame();
    check_val("abort_pre_phase", 32'(vif.phase), 32'(PH_DIM));
    check_val("abort_pre_level", 32'(vif.level), 32'd40);
    vif.abort = 1'b1;
    wait_frame();
    check_val("abort_phase", 32'(vif.phase), 32'(PH_WAKE));
    check_val("abort_level", 32'(vif.level), 32'd41);
    wait_frame();
    check_val("abort_wake_phase", 32'(vif.phase), 32'(PH_WAKE));
    check_val("abort_wake_level", 32'(vif.level), 32'd42);
    vif.abort = 1'b0;

    // Return to IDLE via reset, walk into SLEEP, then reset mid-frame in vsync.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vif.go = 1'b1;
    wait_frame();
    vif.go = 1'b0;
    repeat (63) wait_frame();
    check_val("sleep_phase", 32'(vif.phase), 32'(PH_SLEEP));
    check_val("sleep_level", 32'(vif.level), 32'd0);
    wait_xy(13, 6);
    check_val("pre_rst_hsync", 32'(vif.hsync), 32'd0);
    check_val("pre_rst_vsync", 32'(vif.vsync), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_val("release_x", 32'(vif.x), 32'd0);
    @(negedge clk);
    check_val("count_x", 32'(vif.x), 32'd1);
    lat = 1;
    while (!vif.frame_start && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check_val("first_fs_latency", 32'(lat), 32'(HT * VT - 1));

`ifdef SLEEPWELL_TEST_PATTERN_EN
    wait_xy(3, 1);
    check_val("bar_active", 32'(vif.bar), 32'd0);
    check_val("pattern_level", 32'(vif.level), 32'd63);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sleepwell_vga_ctrl.md
SLEEPWELL_VGA_CTRL -- requirements
Module: sleepwell_vga_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter SLEEP_FRAMES, 120, frames held in SLEEP phase (1..255).
REQ-006 clk  input  1  pixel clock; single clock domain, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 go  input  1  level; request a dim-sleep-wake cycle.
REQ-009 abort  input  1  level; cut DIM/SLEEP short and wake.
REQ-010 hsync, vsync  output  1 each  active-low sync.
REQ-011 de  output  1  display enable (visible region).
REQ-012 x, y  output  10 each  current pixel column / line counters.
REQ-013 frame_start  output  1  one-cycle strobe on last pixel of frame.
REQ-014 phase  output  2  IDLE=0, DIM=1, SLEEP=2, WAKE=3.
REQ-015 level  output  6  brightness for pixel datapath, 63 = full.

Function
REQ-016 H_TOTAL = sum of horizontal params (800); V_TOTAL = sum of vertical params (525).
REQ-017 x increments every clock, wraps H_TOTAL-1 -> 0; y increments on x wrap, wraps V_TOTAL-1 -> 0.
REQ-018 hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751); vsync likewise on y (490..491).
REQ-019 de = 1 iff x < H_ACTIVE and y < V_ACTIVE; hsync, vsync, de decoded from same x, y registers, zero skew.
REQ-020 frame_start = 1 exactly when x = H_TOTAL-1 and y = V_TOTAL-1.
REQ-021 Phase and level change only on the clock edge ending a frame_start cycle; stable for an entire frame.
REQ-022 IDLE: level = 63; if go = 1 at frame_start -> DIM.
REQ-023 DIM: level decrements by 1 per frame; on the frame it reaches 0 -> SLEEP, sleep counter loaded with SLEEP_FRAMES.
REQ-024 SLEEP: level = 0; counter decrements per frame; at counter = 1 -> WAKE.
REQ-025 WAKE: level increments by 1 per frame; on reaching 63 -> IDLE; no wrap past 63 or below 0.
REQ-026 abort = 1 at frame_start in DIM or SLEEP -> WAKE, level continues upward from current value; abort ignored in IDLE/WAKE.
REQ-027 go and abort both 1 at frame_start: abort wins; go ignored outside IDLE.
REQ-028 go/abort sampled only in frame_start cycle; pulses not covering it are lost.

Reset
REQ-029 rst_n low: x = 0, y = 0, phase = IDLE, level = 63, sleep counter = 0, frame_start = 0; hsync = 1, vsync = 1, de = 1 by decode.
REQ-030 Reset mid-cycle aborts any phase immediately; first frame_start after release occurs 420000 clocks later.

Configuration
REQ-031 Macro SLEEPWELL_TEST_PATTERN_EN defined: extra output bar[2:0] = x[9:7] when de = 1, else 0, and level forced 63 whenever go = 0 in IDLE (unchanged otherwise).
REQ-032 Macro undefined: bar port absent, no pattern logic; all other behaviour identical.

Structure
REQ-033 Package sleepwell_pkg holds phase enum, LEVEL_MAX = 63, default timing constants.
REQ-034 Sub-module sleepwell_vga_timing holds x/y counters, sync/de decode and frame_start; phase FSM resides in top.

Verification
REQ-035 Reset release, run 800x525 clocks -> hsync low 96 clocks per line at x = 656, vsync low lines 490..491, de count 307200, frame_start once at (799,524).
REQ-036 go held high, SLEEP_FRAMES = 4 -> level 62..0 over 63 frames, SLEEP 4 frames, WAKE 63 frames to 63, phase returns IDLE after 130 frames.
REQ-037 abort at frame_start with DIM level = 40 -> next frame phase WAKE, level 41.
REQ-038 go and abort both high in IDLE -> phase stays IDLE; go pulse of 1 clock not at frame_start -> no transition.
REQ-039 rst_n low mid-SLEEP at x = 300 -> outputs instantly at reset values; after release x counts from 0.
REQ-040 With SLEEPWELL_TEST_PATTERN_EN: x = 130, y = 10 -> bar = 1; x = 700 -> bar = 0.
